// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the multi-channel memory responder.
// The channel FSM states are shared by the channel sub-module and the top.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP,
    RELEASE
  } mem_resp_state_t;

  // Width of the per-channel latency counter; LATENCY must stay within 1..15.
  localparam int LAT_BITS = 4;

endpackage

// File: rtl/mem_resp_channel.sv
// One responder channel: accept FSM, latency counter and latched request.
// The array itself lives in the top; this block only decides when to sample or commit.
module mem_resp_channel
  import mem_resp_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int LATENCY      = 2,
  parameter int WRITE_ENABLE = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_read_valid,
  input  logic                 i_write_valid,
  input  logic [DATA_BITS-1:0] i_read_word,
  output logic                 o_write_accept,
  output logic                 o_read_ready,
  output logic                 o_write_ready,
  output logic [DATA_BITS-1:0] o_read_data,
  output mem_resp_state_t      o_state
);

  localparam logic [LAT_BITS-1:0] LAT_LOAD = LAT_BITS'(LATENCY - 1);

  mem_resp_state_t      r_state;
  mem_resp_state_t      w_state_next;
  logic [LAT_BITS-1:0]  r_cnt;
  logic [LAT_BITS-1:0]  w_cnt_next;
  logic                 r_is_write;
  logic                 w_is_write_next;
  logic [DATA_BITS-1:0] r_word;
  logic [DATA_BITS-1:0] w_word_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_is_write <= 1'b0;
      r_word     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_is_write <= w_is_write_next;
      r_word     <= w_word_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_cnt_next      = r_cnt;
    w_is_write_next = r_is_write;
    w_word_next     = r_word;
    o_write_accept  = 1'b0;
    case (r_state)
      IDLE: begin
        // Reads win; a concurrent write waits until the read has been released.
        if (i_read_valid) begin
          w_state_next    = BUSY;
          w_cnt_next      = LAT_LOAD;
          w_is_write_next = 1'b0;
          w_word_next     = i_read_word;
        end else if ((WRITE_ENABLE != 0) && i_write_valid) begin
          w_state_next    = BUSY;
          w_cnt_next      = LAT_LOAD;
          w_is_write_next = 1'b1;
          o_write_accept  = 1'b1;
        end
      end
      BUSY: begin
        if (r_cnt == '0) w_state_next = RESP;
        else             w_cnt_next   = r_cnt - 1'b1;
      end
      RESP: w_state_next = RELEASE;
      RELEASE: begin
        // Wait for the requester to drop the valid it used, so one request is served once.
        if (r_is_write ? !i_write_valid : !i_read_valid) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign o_read_ready  = (r_state == RESP) && !r_is_write;
  assign o_write_ready = (WRITE_ENABLE != 0) && (r_state == RESP) && r_is_write;
  assign o_read_data   = o_read_ready ? r_word : '0;
  assign o_state       = r_state;

endmodule

// File: rtl/mem_channel_responder.sv
// Multi-channel valid/ready memory responder with fixed latency and a backdoor load port.
// Owns the shared array, the same-edge write priority and the completed-access counter.
module mem_channel_responder
  import mem_resp_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int NUM_CHANNELS = 4,
  parameter int LATENCY      = 2,
  parameter int WRITE_ENABLE = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    load_en,
  input  logic [ADDR_BITS-1:0]    load_addr,
  input  logic [DATA_BITS-1:0]    load_data,
  input  logic [NUM_CHANNELS-1:0] mem_read_valid,
  input  logic [ADDR_BITS-1:0]    mem_read_address [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] mem_read_ready,
  output logic [DATA_BITS-1:0]    mem_read_data    [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0] mem_write_valid,
  input  logic [ADDR_BITS-1:0]    mem_write_address [NUM_CHANNELS],
  input  logic [DATA_BITS-1:0]    mem_write_data    [NUM_CHANNELS],
  output logic [NUM_CHANNELS-1:0] mem_write_ready,
  output logic [15:0]             access_count
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_BITS-1:0]    r_mem [DEPTH];
  logic [DATA_BITS-1:0]    w_rd_word [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] w_wr_accept;
  mem_resp_state_t         w_state [NUM_CHANNELS];
  logic [15:0]             r_access_count;
  logic [16:0]             w_resp_num;
  logic [16:0]             w_count_sum;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    // Combinational array read: a same-edge write is not yet visible, so reads see the old word.
    assign w_rd_word[g] = r_mem[mem_read_address[g]];

    mem_resp_channel #(
      .DATA_BITS   (DATA_BITS),
      .LATENCY     (LATENCY),
      .WRITE_ENABLE(WRITE_ENABLE)
    ) u_ch (
      .clk           (clk),
      .reset_n       (reset_n),
      .i_read_valid  (mem_read_valid[g]),
      .i_write_valid (mem_write_valid[g]),
      .i_read_word   (w_rd_word[g]),
      .o_write_accept(w_wr_accept[g]),
      .o_read_ready  (mem_read_ready[g]),
      .o_write_ready (mem_write_ready[g]),
      .o_read_data   (mem_read_data[g]),
      .o_state       (w_state[g])
    );
  end

  // Later assignments win: higher channel index over lower, backdoor load over all channels.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (w_wr_accept[c]) r_mem[mem_write_address[c]] <= mem_write_data[c];
    end
    if (load_en) r_mem[load_addr] <= load_data;
  end

  always_comb begin
    w_resp_num = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (w_state[c] == RESP) w_resp_num = w_resp_num + 17'd1;
    end
    w_count_sum = {1'b0, r_access_count} + w_resp_num;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_access_count <= '0;
    else          r_access_count <= w_count_sum[16] ? 16'hFFFF : w_count_sum[15:0];
  end

  assign access_count = r_access_count;

endmodule

// File: tb/tb_mem_channel_responder.sv
// Self-checking bench for mem_channel_responder: a read/write instance plus a read-only instance.
// Read responses are predicted into a queue at request time and matched as ready pulses appear.
module tb_mem_channel_responder;

  localparam int AB  = 8;
  localparam int DB  = 8;
  localparam int NC  = 4;
  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic          load_en;
  logic [AB-1:0] load_addr;
  logic [DB-1:0] load_data;
  logic [NC-1:0] rd_valid, rd_ready, wr_valid, wr_ready;
  logic [AB-1:0] rd_addr [NC];
  logic [DB-1:0] rd_data [NC];
  logic [AB-1:0] wr_addr [NC];
  logic [DB-1:0] wr_data [NC];
  logic [15:0]   acc_cnt;

  logic          ro_load_en;
  logic [AB-1:0] ro_load_addr;
  logic [DB-1:0] ro_load_data;
  logic [NC-1:0] ro_rd_valid, ro_rd_ready, ro_wr_valid, ro_wr_ready;
  logic [AB-1:0] ro_rd_addr [NC];
  logic [DB-1:0] ro_rd_data [NC];
  logic [AB-1:0] ro_wr_addr [NC];
  logic [DB-1:0] ro_wr_data [NC];
  logic [15:0]   ro_acc_cnt;

  mem_channel_responder #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(LAT), .WRITE_ENABLE(1)
  ) u_dut (
    .clk(clk), .reset_n(reset_n),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .mem_read_valid(rd_valid), .mem_read_address(rd_addr),
    .mem_read_ready(rd_ready), .mem_read_data(rd_data),
    .mem_write_valid(wr_valid), .mem_write_address(wr_addr), .mem_write_data(wr_data),
    .mem_write_ready(wr_ready), .access_count(acc_cnt)
  );

  mem_channel_responder #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(LAT), .WRITE_ENABLE(0)
  ) u_dut_ro (
    .clk(clk), .reset_n(reset_n),
    .load_en(ro_load_en), .load_addr(ro_load_addr), .load_data(ro_load_data),
    .mem_read_valid(ro_rd_valid), .mem_read_address(ro_rd_addr),
    .mem_read_ready(ro_rd_ready), .mem_read_data(ro_rd_data),
    .mem_write_valid(ro_wr_valid), .mem_write_address(ro_wr_addr), .mem_write_data(ro_wr_data),
    .mem_write_ready(ro_wr_ready), .access_count(ro_acc_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [DB+1:0] exp_q[$];   // {channel, data}
  logic [DB+1:0] mon_e;
  int rd_pulses [NC];
  int wr_pulses [NC];
  logic [NC-1:0] prev_rd = '0;
  int exp_acc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  initial for (int c = 0; c < NC; c++) begin rd_pulses[c] = 0; wr_pulses[c] = 0; end

  always @(negedge clk) begin
    for (int c = 0; c < NC; c++) begin
      if (rd_ready[c]) begin
        rd_pulses[c]++;
        if (prev_rd[c]) check("rd_pulse_width", 32'd2, 32'd1);
        if (exp_q.size() == 0) begin
          check("rd_unexpected_ch", 32'(c), 32'hFFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("rd_resp", {22'd0, 2'(c), rd_data[c]}, {22'd0, mon_e});
        end
      end else if (rd_data[c] != '0) begin
        check("rd_data_idle", 32'(rd_data[c]), 32'd0);
      end
      if (wr_ready[c]) wr_pulses[c]++;
    end
    prev_rd = rd_ready;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_pulse(input int ch, input bit is_wr, output int k);
    int i;
    k = 0;
    i = 0;
    while (k == 0 && i < 40) begin
      @(negedge clk);
      i++;
      if (is_wr ? wr_ready[ch] : rd_ready[ch]) k = i;
    end
    if (k == 0) check(is_wr ? "wr_timeout" : "rd_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_read(input int ch, input logic [AB-1:0] addr, input logic [DB-1:0] exp,
                         input bit scramble);
    int k;
    @(negedge clk);
    rd_addr[ch]  = addr;
    rd_valid[ch] = 1'b1;
    exp_q.push_back({2'(ch), exp});
    if (scramble) begin
      @(negedge clk);
      rd_addr[ch] = ~addr;   // already accepted: must not affect the returned word
      wait_pulse(ch, 1'b0, k);
      k = k + 1;
    end else begin
      wait_pulse(ch, 1'b0, k);
    end
    check("rd_latency", 32'(k - 1), 32'(LAT));
    rd_valid[ch] = 1'b0;
    exp_acc++;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_write(input int ch, input logic [AB-1:0] addr, input logic [DB-1:0] data);
    int k;
    @(negedge clk);
    wr_addr[ch]  = addr;
    wr_data[ch]  = data;
    wr_valid[ch] = 1'b1;
    wait_pulse(ch, 1'b1, k);
    check("wr_latency", 32'(k - 1), 32'(LAT));
    wr_valid[ch] = 1'b0;
    exp_acc++;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    int k, k2, p0, c1, c2;
    logic [NC-1:0] seen;
    reset_n = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    ro_load_en = 1'b0; ro_load_addr = '0; ro_load_data = '0;
    rd_valid = '1; wr_valid = '0; ro_rd_valid = '0; ro_wr_valid = '0;
    for (int c = 0; c < NC; c++) begin
      rd_addr[c] = AB'(c); wr_addr[c] = '0; wr_data[c] = '0;
      ro_rd_addr[c] = '0; ro_wr_addr[c] = '0; ro_wr_data[c] = '0;
    end

    // 1. reset with valids high; backdoor-load words while in reset
    for (int c = 0; c < NC; c++) begin
      @(negedge clk);
      load_en = 1'b1; load_addr = AB'(c); load_data = DB'(8'hA0 + c);
    end
    @(negedge clk);
    load_en = 1'b0;
    check("rst_rd_ready", 32'(rd_ready), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_rd_data0", 32'(rd_data[0]), 32'd0);
    check("rst_acc", 32'(acc_cnt), 32'd0);
    for (int c = 0; c < NC; c++) exp_q.push_back({2'(c), DB'(8'hA0 + c)});
    reset_n = 1'b1;
    wait_pulse(0, 1'b0, k);
    check("rst_release_latency", 32'(k - 1), 32'(LAT));
    check("rst_release_all_ready", 32'(rd_ready), 32'hF);
    rd_valid = '0;
    exp_acc = 4;
    repeat (3) @(negedge clk);
    check("acc_after_release", 32'(acc_cnt), 32'(exp_acc));

    // 2. backdoor load then read, with address changed after accept
    @(negedge clk);
    load_en = 1'b1; load_addr = 8'h10; load_data = 8'h2A;
    @(negedge clk);
    load_en = 1'b0;
    do_read(0, 8'h10, 8'h2A, 1'b1);
    check("acc_after_load_read", 32'(acc_cnt), 32'(exp_acc));

    // 3. write then read on ch1
    do_write(1, 8'h03, 8'h55);
    do_read(1, 8'h03, 8'h55, 1'b0);

    // 4a. ch0 and ch3 write the same address in one edge: ch3 wins
    @(negedge clk);
    wr_addr[0] = 8'h07; wr_data[0] = 8'h11; wr_addr[3] = 8'h07; wr_data[3] = 8'h33;
    wr_valid[0] = 1'b1; wr_valid[3] = 1'b1;
    wait_pulse(3, 1'b1, k);
    check("coll_both_wr_ready", 32'(wr_ready), 32'h9);
    wr_valid = '0; exp_acc += 2;
    repeat (2) @(negedge clk);
    do_read(2, 8'h07, 8'h33, 1'b0);

    // 4b. backdoor load in the same edge beats both channel writes
    @(negedge clk);
    wr_data[0] = 8'h44; wr_data[3] = 8'h66; wr_valid[0] = 1'b1; wr_valid[3] = 1'b1;
    load_en = 1'b1; load_addr = 8'h07; load_data = 8'h99;
    @(negedge clk);
    load_en = 1'b0;
    wait_pulse(3, 1'b1, k);
    wr_valid = '0; exp_acc += 2;
    repeat (2) @(negedge clk);
    do_read(2, 8'h07, 8'h99, 1'b0);

    // 4c. read of an address written in the same edge returns the old word
    @(negedge clk);
    rd_addr[1] = 8'h07; rd_valid[1] = 1'b1;
    wr_addr[0] = 8'h07; wr_data[0] = 8'h44; wr_valid[0] = 1'b1;
    exp_q.push_back({2'd1, 8'h99});
    wait_pulse(1, 1'b0, k);
    rd_valid[1] = 1'b0; wr_valid[0] = 1'b0; exp_acc += 2;
    repeat (2) @(negedge clk);
    do_read(2, 8'h07, 8'h44, 1'b0);

    // 4d. read and write together on one channel: read first, write after release
    @(negedge clk);
    rd_addr[0] = 8'h10; rd_valid[0] = 1'b1;
    wr_addr[0] = 8'h08; wr_data[0] = 8'h5A; wr_valid[0] = 1'b1;
    exp_q.push_back({2'd0, 8'h2A});
    wait_pulse(0, 1'b0, k);
    check("prio_read_first_no_wr", 32'(wr_ready[0]), 32'd0);
    rd_valid[0] = 1'b0;
    wait_pulse(0, 1'b1, k2);
    check("pending_write_gap", 32'(k2), 32'(LAT + 3));
    wr_valid[0] = 1'b0; exp_acc += 2;
    repeat (2) @(negedge clk);
    do_read(0, 8'h08, 8'h5A, 1'b0);

    // 5. held valid gives a single pulse; re-raise gives a second one
    p0 = rd_pulses[2];
    @(negedge clk);
    rd_addr[2] = 8'h10; rd_valid[2] = 1'b1;
    exp_q.push_back({2'd2, 8'h2A});
    wait_pulse(2, 1'b0, k);
    c1 = cyc;
    repeat (6) @(negedge clk);
    check("held_valid_pulses", 32'(rd_pulses[2] - p0), 32'd1);
    rd_valid[2] = 1'b0;
    @(negedge clk);
    rd_valid[2] = 1'b1;
    exp_q.push_back({2'd2, 8'h2A});
    wait_pulse(2, 1'b0, k);
    c2 = cyc;
    check("rerequest_latency", 32'(k - 1), 32'(LAT));
    check("rerequest_spacing_ok", 32'((c2 - c1) >= (LAT + 2)), 32'd1);
    rd_valid[2] = 1'b0; exp_acc += 2;
    repeat (3) @(negedge clk);
    check("held_valid_total_pulses", 32'(rd_pulses[2] - p0), 32'd2);
    check("acc_before_mid_reset", 32'(acc_cnt), 32'(exp_acc));

    // 6. async reset while ch0 is BUSY: transaction dropped
    p0 = rd_pulses[0];
    @(negedge clk);
    rd_addr[0] = 8'h10; rd_valid[0] = 1'b1;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_rd_ready", 32'(rd_ready), 32'd0);
    check("mid_rst_acc", 32'(acc_cnt), 32'd0);
    check("mid_rst_rd_data0", 32'(rd_data[0]), 32'd0);
    rd_valid[0] = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("no_stray_ready", 32'(rd_pulses[0] - p0), 32'd0);
    check("acc_after_mid_reset", 32'(acc_cnt), 32'd0);

    // 6b. read-only build: writes ignored, array unchanged
    @(negedge clk);
    ro_load_en = 1'b1; ro_load_addr = 8'h20; ro_load_data = 8'h77;
    @(negedge clk);
    ro_load_en = 1'b0;
    ro_wr_addr[0] = 8'h20; ro_wr_data[0] = 8'hEE; ro_wr_valid[0] = 1'b1;
    seen = '0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | ro_wr_ready;
    end
    check("ro_write_ready", 32'(seen), 32'd0);
    ro_wr_valid[0] = 1'b0;
    ro_rd_addr[0] = 8'h20; ro_rd_valid[0] = 1'b1;
    k = 0;
    for (int i = 1; i <= 40 && k == 0; i++) begin
      @(negedge clk);
      if (ro_rd_ready[0]) begin
        k = i;
        check("ro_read_data", 32'(ro_rd_data[0]), 32'h77);
      end
    end
    if (k == 0) check("ro_rd_timeout", 32'd0, 32'd1);
    ro_rd_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("ro_acc", 32'(ro_acc_cnt), 32'd1);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
